hazard_controller: RTL and testbench

- Pipeline control unit that drives the rr_stall / rr_flush pair consumed by decode_stage and the fetch side.
- Keeps a per-register load scoreboard and detects load-use hazards on the instruction currently held in the decode output registers.
- Arbitrates three stall/flush sources with fixed priority: execute-stage redirect (branch/JAL), memory-stage busy, load-use hazard.
- Sits between decode outputs and the register-read stage.

---
 rtl/hazard_controller.sv | 136 +++++++++++++
 tb/tb_hazard_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline control unit for the register-read boundary. Tracks in-flight
//   loads in a 16-entry scoreboard, detects load-use hazards on the
//   instruction held in the decode output registers, and arbitrates
//   redirect flush > memory busy > load-use hazard into rr_stall/rr_flush.
//
// Ports
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   decode_valid/op/rd/rs/rt instruction in the decode output registers
//   ex_redirect             taken branch/JAL resolved in execute
//   mem_busy                memory stage cannot accept an instruction
//   rr_stall                hold fetch/decode (combinational)
//   rr_flush                squash fetch/decode (registered)
//   ctrl_state              0=RUN 1=HAZ 2=MEM 3=FLUSH (registered)
//   stall_cycles            saturating count of stalled cycles

`ifndef OPCODE_LW
`define OPCODE_LW  6'h23
`endif
`ifndef OPCODE_SW
`define OPCODE_SW  6'h2B
`endif
`ifndef OPCODE_BEQ
`define OPCODE_BEQ 6'h04
`endif
`ifndef OPCODE_BNE
`define OPCODE_BNE 6'h05
`endif
`ifndef OPCODE_BLT
`define OPCODE_BLT 6'h06
`endif
`ifndef OPCODE_BLE
`define OPCODE_BLE 6'h07
`endif

module hazard_controller #(
    parameter int LOAD_LAT     = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        decode_valid,
    input  logic [5:0]  decode_op,
    input  logic [3:0]  decode_rd,
    input  logic [3:0]  decode_rs,
    input  logic [3:0]  decode_rt,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        rr_stall,
    output logic        rr_flush,
    output logic [1:0]  ctrl_state,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_MEM   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         fc_q, fc_d;
    logic               flush_q, flush_d;
    logic [15:0]        sc_q, sc_d;
    logic [15:0][1:0]   cnt_q, cnt_d;

    logic rt_used, hazard, issue, is_lw;

    always_comb begin
        rt_used = (decode_op == 6'h00) || (decode_op == `OPCODE_BEQ) ||
                  (decode_op == `OPCODE_BLT) || (decode_op == `OPCODE_BLE) ||
                  (decode_op == `OPCODE_BNE) || (decode_op == `OPCODE_SW);
        hazard  = decode_valid &&
                  (((cnt_q[decode_rs] != 2'd0) && (decode_rs != 4'd0)) ||
                   (rt_used && (cnt_q[decode_rt] != 2'd0) && (decode_rt != 4'd0)));
        is_lw   = (decode_op == `OPCODE_LW);
        rr_flush = flush_q;
        // Flush squashes the decode slot, so stalling it would be pointless.
        rr_stall = i_reset_n && !flush_q && (mem_busy || hazard);
        issue    = decode_valid && !rr_stall && !flush_q;
    end

    // Scoreboard: age every pending entry, then let a new load overwrite.
    always_comb begin
        cnt_d = cnt_q;
        if (!mem_busy) begin
            for (int r = 0; r < 16; r++) begin
                if (cnt_q[r] != 2'd0)
                    cnt_d[r] = cnt_q[r] - 2'd1;
                if (issue && is_lw && (decode_rd == 4'(r)) && (r != 0))
                    cnt_d[r] = 2'(LOAD_LAT);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        if (ex_redirect) begin
            state_d = ST_FLUSH;
            fc_d    = 2'(FLUSH_CYCLES);
        end else if (state_q == ST_FLUSH) begin
            if (fc_q != 2'd0)
                fc_d = fc_q - 2'd1;
            if (fc_d == 2'd0)
                state_d = mem_busy ? ST_MEM : (hazard ? ST_HAZ : ST_RUN);
        end else begin
            state_d = mem_busy ? ST_MEM : (hazard ? ST_HAZ : ST_RUN);
        end
        flush_d = (fc_d != 2'd0);
        sc_d    = sc_q;
        if (rr_stall && (sc_q != 16'hFFFF))
            sc_d = sc_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_RUN;
            fc_q    <= 2'd0;
            flush_q <= 1'b0;
            sc_q    <= 16'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            flush_q <= flush_d;
            sc_q    <= sc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ctrl_state   = state_q;
    assign stall_cycles = sc_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: each cycle's stimulus pushes the
// hand-computed expected outputs into a queue; a monitor on the falling
// edge pops and compares.
module tb_hazard_controller;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ALUI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        dv = 0;
    logic [5:0]  op = 0;
    logic [3:0]  rd = 0, rs = 0, rt = 0;
    logic        redir = 0, busy = 0;
    logic        rr_stall, rr_flush;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string name;
        logic  stall;
        logic  flush;
        logic [1:0] state;
        int    sc;      // -1: do not compare
    } exp_t;

    exp_t q[$];

    hazard_controller #(.LOAD_LAT(2), .FLUSH_CYCLES(2)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .decode_valid(dv), .decode_op(op), .decode_rd(rd),
        .decode_rs(rs), .decode_rt(rt),
        .ex_redirect(redir), .mem_busy(busy),
        .rr_stall(rr_stall), .rr_flush(rr_flush),
        .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: drive after the rising edge, queue what this cycle must show.
    task automatic cyc(input string name, input logic r, input logic v,
                       input logic [5:0] o, input logic [3:0] d,
                       input logic [3:0] s, input logic [3:0] t,
                       input logic rdr, input logic b,
                       input logic es, input logic ef, input logic [1:0] est,
                       input int esc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; dv = v; op = o; rd = d; rs = s; rt = t; redir = rdr; busy = b;
        e.name = name; e.stall = es; e.flush = ef; e.state = est; e.sc = esc;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, ".stall"}, int'(rr_stall), int'(e.stall));
                chk({e.name, ".flush"}, int'(rr_flush), int'(e.flush));
                chk({e.name, ".state"}, int'(ctrl_state), int'(e.state));
                if (e.sc >= 0)
                    chk({e.name, ".sc"}, int'(stall_cycles), e.sc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        //   name     rst v  op       rd rs rt rdr b   stall flush st sc
        cyc("rst0",   0, 0, OP_R,    0, 0, 0, 0, 0,  0, 0, 0, 0);
        cyc("rst1",   0, 0, OP_R,    0, 0, 0, 0, 0,  0, 0, 0, 0);
        cyc("rst2",   0, 0, OP_R,    0, 0, 0, 0, 0,  0, 0, 0, 0);
        cyc("idle",   1, 0, OP_R,    0, 0, 0, 0, 0,  0, 0, 0, 0);

        // load-use: two-cycle stall behind LW r5
        cyc("lu_lw",  1, 1, OP_LW,   5, 1, 0, 0, 0,  0, 0, 0, 0);
        cyc("lu_s1",  1, 1, OP_R,    0, 5, 2, 0, 0,  1, 0, 0, 0);
        cyc("lu_s2",  1, 1, OP_R,    0, 5, 2, 0, 0,  1, 0, 1, 1);
        cyc("lu_iss", 1, 1, OP_R,    0, 5, 2, 0, 0,  0, 0, 1, 2);
        cyc("lu_end", 1, 0, OP_R,    0, 0, 0, 0, 0,  0, 0, 0, 2);

        // ALUI ignores rt; LW to r0 never creates a dependency
        cyc("nf_lw",  1, 1, OP_LW,   5, 1, 0, 0, 0,  0, 0, 0, -1);
        cyc("nf_alu", 1, 1, OP_ALUI, 6, 3, 5, 0, 0,  0, 0, 0, 2);
        cyc("nf_gap", 1, 0, OP_R,    0, 0, 0, 0, 0,  0, 0, 0, -1);
        cyc("r0_lw",  1, 1, OP_LW,   0, 1, 0, 0, 0,  0, 0, 0, -1);
        cyc("r0_rd",  1, 1, OP_R,    1, 0, 0, 0, 0,  0, 0, 0, 2);
        cyc("r0_end", 1, 0, OP_R,    0, 0, 0, 0, 0,  0, 0, 0, -1);

        // single redirect; mem_busy inside the flush must not stall
        cyc("rd_p",   1, 0, OP_R,    0, 0, 0, 1, 0,  0, 0, 0, -1);
        cyc("rd_f1",  1, 0, OP_R,    0, 0, 0, 0, 1,  0, 1, 3, -1);
        cyc("rd_f2",  1, 0, OP_R,    0, 0, 0, 0, 0,  0, 1, 3, -1);
        cyc("rd_run", 1, 0, OP_R,    0, 0, 0, 0, 0,  0, 0, 0, 2);

        // second redirect during the flush restarts the count
        cyc("rr_p1",  1, 0, OP_R,    0, 0, 0, 1, 0,  0, 0, 0, -1);
        cyc("rr_f1",  1, 0, OP_R,    0, 0, 0, 0, 0,  0, 1, 3, -1);
        cyc("rr_p2",  1, 0, OP_R,    0, 0, 0, 1, 0,  0, 1, 3, -1);
        cyc("rr_f2",  1, 0, OP_R,    0, 0, 0, 0, 0,  0, 1, 3, -1);
        cyc("rr_f3",  1, 0, OP_R,    0, 0, 0, 0, 0,  0, 1, 3, -1);
        cyc("rr_run", 1, 0, OP_R,    0, 0, 0, 0, 0,  0, 0, 0, 2);

        // redirect together with mem_busy: stall this cycle, FLUSH next
        cyc("rb_p",   1, 0, OP_R,    0, 0, 0, 1, 1,  1, 0, 0, 2);
        cyc("rb_f1",  1, 0, OP_R,    0, 0, 0, 0, 0,  0, 1, 3, 3);
        cyc("rb_f2",  1, 0, OP_R,    0, 0, 0, 0, 0,  0, 1, 3, -1);
        cyc("rb_run", 1, 0, OP_R,    0, 0, 0, 0, 0,  0, 0, 0, 3);

        // mem_busy freezes the scoreboard: 3 busy + 2 hazard cycles
        cyc("mb_lw",  1, 1, OP_LW,   7, 0, 0, 0, 0,  0, 0, 0, 3);
        cyc("mb_b1",  1, 1, OP_SW,   0, 1, 7, 0, 1,  1, 0, 0, -1);
        cyc("mb_b2",  1, 1, OP_SW,   0, 1, 7, 0, 1,  1, 0, 2, 4);
        cyc("mb_b3",  1, 1, OP_SW,   0, 1, 7, 0, 1,  1, 0, 2, 5);
        cyc("mb_h1",  1, 1, OP_SW,   0, 1, 7, 0, 0,  1, 0, 2, 6);
        cyc("mb_h2",  1, 1, OP_SW,   0, 1, 7, 0, 0,  1, 0, 1, 7);
        cyc("mb_iss", 1, 1, OP_SW,   0, 1, 7, 0, 0,  0, 0, 1, 8);
        cyc("mb_end", 1, 0, OP_R,    0, 0, 0, 0, 0,  0, 0, 0, 8);

        // async reset during FLUSH with r9 held pending by mem_busy
        cyc("ar_lw",  1, 1, OP_LW,   9, 0, 0, 0, 0,  0, 0, 0, -1);
        cyc("ar_p",   1, 0, OP_R,    0, 0, 0, 1, 1,  1, 0, 0, 8);
        cyc("ar_f1",  1, 0, OP_R,    0, 0, 0, 0, 1,  0, 1, 3, 9);
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("ar_async.flush", int'(rr_flush), 0);
        chk("ar_async.state", int'(ctrl_state), 0);
        chk("ar_async.stall", int'(rr_stall), 0);
        chk("ar_async.sc", int'(stall_cycles), 0);
        cyc("ar_hold", 0, 1, OP_R,   0, 9, 0, 0, 1,  0, 0, 0, 0);
        cyc("ar_rel",  1, 1, OP_R,   0, 9, 9, 0, 0,  0, 0, 0, 0);
        cyc("ar_end",  1, 0, OP_R,   0, 0, 0, 0, 0,  0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
